// File: rtl/cross2x2_sched.sv
// cross2x2_sched: per-input FIFOs plus per-output round-robin scheduling in front of a 2x2 crossbar.
// The valid/ready handshake to the crossbar outputs is run here, so the crossbar itself stays combinational.

// cross2x2_fifo: generic circular FIFO with occupancy counter; head visible while non-empty.
// Latency: a word pushed at edge t appears at the head from cycle t+1.
// Backpressure: push_rdy = !full, independent of a same-cycle pop; held low during reset.
module cross2x2_fifo #(
   parameter int W     = 3,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_vld,
   output logic         push_rdy,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic         empty,
   output logic [W-1:0] head_dat
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] cnt;
   logic          full, push, pop_ok;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign push_rdy = rst_n && !full;
   assign push     = push_vld && push_rdy;
   assign pop_ok   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)   wr_ptr <= nxt(wr_ptr);
         if (pop_ok) rd_ptr <= nxt(rd_ptr);
         case ({push, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// cross2x2_sched: buffers two tagged input streams and round-robin schedules them onto two outputs.
// Latency: one cycle from input push to crossbar output; no combinational in->out path.
// Backpressure: stalled outputs hold valid/sel/data; inputs back off only when their FIFO is full.
module cross2x2_sched #(
   parameter int DATA_W = 2,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in0_valid,
   output logic              in0_ready,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in0_dest,
   input  logic              in1_valid,
   output logic              in1_ready,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_dest,
   output logic [DATA_W-1:0] xb_in0,
   output logic [DATA_W-1:0] xb_in1,
   output logic              sel0,
   output logic              sel1,
   output logic              out0_valid,
   input  logic              out0_ready,
   output logic              out1_valid,
   input  logic              out1_ready
);
   typedef struct packed {
      logic              dest;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t       head0, head1;
   logic       empty0, empty1, pop0, pop1;
   // Bit d of each vector below refers to output d.
   logic [1:0] req0, req1, vld, gnt, sel_w, xfer;
   logic [1:0] rr, last_gnt;

   cross2x2_fifo #(.W($bits(ent_t)), .DEPTH(DEPTH)) u_fifo0 (
      .clk(clk), .rst_n(rst_n),
      .push_vld(in0_valid), .push_rdy(in0_ready), .push_dat({in0_dest, in0_data}),
      .pop(pop0), .empty(empty0), .head_dat(head0)
   );

   cross2x2_fifo #(.W($bits(ent_t)), .DEPTH(DEPTH)) u_fifo1 (
      .clk(clk), .rst_n(rst_n),
      .push_vld(in1_valid), .push_rdy(in1_ready), .push_dat({in1_dest, in1_data}),
      .pop(pop1), .empty(empty1), .head_dat(head1)
   );

   assign req0 = {~empty0 & head0.dest, ~empty0 & ~head0.dest};
   assign req1 = {~empty1 & head1.dest, ~empty1 & ~head1.dest};
   assign vld  = req0 | req1;
   // Contention takes the round-robin pointer; otherwise the sole requester (input 1 iff it requests).
   assign gnt   = (req0 & req1 & rr) | (~(req0 & req1) & req1);
   assign sel_w = (vld & gnt) | (~vld & last_gnt);
   assign xfer  = vld & {out1_ready, out0_ready};
   assign pop0  = |(xfer & ~gnt);
   assign pop1  = |(xfer & gnt);

   assign xb_in0     = empty0 ? '0 : head0.data;
   assign xb_in1     = empty1 ? '0 : head1.data;
   assign out0_valid = vld[0];
   assign out1_valid = vld[1];
   assign sel0       = sel_w[0];
   assign sel1       = sel_w[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr       <= '0;
         last_gnt <= '0;
      end else begin
         rr       <= (rr & ~xfer) | (~gnt & xfer);
         last_gnt <= (last_gnt & ~xfer) | (gnt & xfer);
      end
   end
endmodule

// File: tb/tb_cross2x2_sched.sv
// Bench for cross2x2_sched: vector table, directed corner sequences, and random traffic against a queue model.
module tb_cross2x2_sched;
   localparam int DW    = 2;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in0_valid = 1'b0, in0_dest = 1'b0, in1_valid = 1'b0, in1_dest = 1'b0;
   logic [DW-1:0] in0_data = '0, in1_data = '0;
   logic          in0_ready, in1_ready;
   logic [DW-1:0] xb_in0, xb_in1;
   logic          sel0, sel1, out0_valid, out1_valid;
   logic          out0_ready = 1'b0, out1_ready = 1'b0;

   cross2x2_sched #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_dest(in0_dest),
      .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_dest(in1_dest),
      .xb_in0(xb_in0), .xb_in1(xb_in1), .sel0(sel0), .sel1(sel1),
      .out0_valid(out0_valid), .out0_ready(out0_ready),
      .out1_valid(out1_valid), .out1_ready(out1_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          dest;
      logic [DW-1:0] data;
   } ent_t;

   // Reference model: two word queues, preferred input and last grant per output.
   ent_t q0[$];
   ent_t q1[$];
   int   pref[2];
   int   lastg[2];

   int         tests = 0;
   int         fails = 0;
   logic [9:0] last_act;

   // Observation vector: {in0_ready,in1_ready,xb_in0,xb_in1,sel0,sel1,out0_valid,out1_valid}
   function automatic logic [9:0] cur_act();
      return {in0_ready, in1_ready, xb_in0, xb_in1, sel0, sel1, out0_valid, out1_valid};
   endfunction

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      pref[0] = 0; pref[1] = 0;
      lastg[0] = 0; lastg[1] = 0;
   endtask

   // One clock cycle: drive inputs, compare DUT against the model, then advance the model past the edge.
   task automatic step(input logic v0, input logic [DW-1:0] dt0, input logic ds0,
                       input logic v1, input logic [DW-1:0] dt1, input logic ds1,
                       input logic r0, input logic r1);
      logic          rq0[2], rq1[2], vld[2], s[2], rd[2];
      int            g[2];
      logic          rdy0, rdy1;
      logic [DW-1:0] xb0, xb1;
      @(negedge clk);
      in0_valid = v0; in0_data = dt0; in0_dest = ds0;
      in1_valid = v1; in1_data = dt1; in1_dest = ds1;
      out0_ready = r0; out1_ready = r1;
      #1;
      rdy0 = q0.size() < DEPTH;
      rdy1 = q1.size() < DEPTH;
      xb0  = (q0.size() > 0) ? q0[0].data : '0;
      xb1  = (q1.size() > 0) ? q1[0].data : '0;
      rd[0] = r0; rd[1] = r1;
      for (int d = 0; d < 2; d++) begin
         rq0[d] = (q0.size() > 0) && (int'(q0[0].dest) == d);
         rq1[d] = (q1.size() > 0) && (int'(q1[0].dest) == d);
         vld[d] = rq0[d] || rq1[d];
         g[d]   = (rq0[d] && rq1[d]) ? pref[d] : (rq1[d] ? 1 : 0);
         s[d]   = vld[d] ? (g[d] == 1) : (lastg[d] == 1);
      end
      last_act = cur_act();
      chk("model", last_act, {rdy0, rdy1, xb0, xb1, s[0], s[1], vld[0], vld[1]});
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (vld[d] && rd[d]) begin
            if (g[d] == 0) void'(q0.pop_front());
            else           void'(q1.pop_front());
            lastg[d] = g[d];
            pref[d]  = 1 - g[d];
         end
      end
      if (v0 && rdy0) q0.push_back(ent_t'({ds0, dt0}));
      if (v1 && rdy1) q1.push_back(ent_t'({ds1, dt1}));
   endtask

   task automatic idle(input logic r0, input logic r1);
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, r0, r1);
   endtask

   // Asserts reset away from any clock edge, checks the reset outputs, releases on a falling edge.
   task automatic reset_pulse(input string name);
      @(negedge clk);
      in0_valid = 1'b0; in1_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk(name, cur_act(), 10'b0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic          v0;
      logic [DW-1:0] dt0;
      logic          ds0;
      logic          v1;
      logic [DW-1:0] dt1;
      logic          ds1;
      logic          r0;
      logic          r1;
      logic [9:0]    exp;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required $finish before 200000");
      $fatal(1);
   end

   initial begin
      logic          e_sel;
      logic [DW-1:0] od;

      tbl[0] = '{1'b1, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 10'b11_00_00_0000};
      tbl[1] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 10'b11_01_00_0001};
      tbl[2] = '{1'b1, 2'b11, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 10'b11_00_00_0000};
      tbl[3] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 10'b11_11_10_0111};
      tbl[4] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 10'b11_00_00_0100};

      model_clear();
      repeat (2) @(negedge clk);
      chk("reset_state", cur_act(), 10'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single word, then two simultaneous words to different outputs.
      for (int i = 0; i < 5; i++) begin
         step(tbl[i].v0, tbl[i].dt0, tbl[i].ds0, tbl[i].v1, tbl[i].dt1, tbl[i].ds1, tbl[i].r0, tbl[i].r1);
         chk($sformatf("vec%0d", i), last_act, tbl[i].exp);
      end

      // Continuous contention on Out0: grants alternate starting from input 0.
      reset_pulse("reset_rr");
      for (int k = 0; k < 9; k++) begin
         step(1'b1, 2'd1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
         if (k >= 1) begin
            e_sel = ((k - 1) % 2) == 1;
            od    = last_act[3] ? last_act[5:4] : last_act[7:6];
            chk($sformatf("rr_seq%0d", k), {6'b0, last_act[1], last_act[3], od},
                {6'b0, 1'b1, e_sel, e_sel ? 2'd2 : 2'd1});
         end
      end

      // Stall Out0 while pushing four words: two accepted, outputs held stable.
      reset_pulse("reset_stall");
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 2'(k + 1), 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("stall_rdy%0d", k), {9'b0, last_act[9]}, {9'b0, k < 2});
         if (k >= 1)
            chk($sformatf("stall_hold%0d", k), {6'b0, last_act[1], last_act[3], last_act[7:6]},
                {6'b0, 1'b1, 1'b0, 2'd1});
      end
      // Release while the full FIFO is offered another word: refused once, then taken.
      step(1'b1, 2'd3, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("drain0", {7'b0, last_act[9], last_act[1], last_act[7:6]} >> 1, {7'b0, 1'b0, 1'b1, 2'd1} >> 1);
      chk("drain0_data", {8'b0, last_act[7:6]}, {8'b0, 2'd1});
      step(1'b1, 2'd3, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("drain1", {6'b0, last_act[9], last_act[1], last_act[7:6]}, {6'b0, 1'b1, 1'b1, 2'd2});
      idle(1'b1, 1'b0);
      chk("drain2", {6'b0, last_act[9], last_act[1], last_act[7:6]}, {6'b0, 1'b1, 1'b1, 2'd3});
      idle(1'b1, 1'b0);
      chk("drain_empty", {6'b0, last_act[9], last_act[1], last_act[7:6]}, {6'b0, 1'b1, 1'b0, 2'd0});

      // Reset with both FIFOs half full, then check restart behaviour.
      reset_pulse("reset_pre_mid");
      step(1'b1, 2'd1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      reset_pulse("reset_mid");
      for (int k = 0; k < 3; k++) begin
         idle(1'b1, 1'b1);
         chk($sformatf("post_rst_idle%0d", k), {8'b0, last_act[1:0]}, 10'b0);
      end
      step(1'b1, 2'd3, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
      idle(1'b1, 1'b1);
      chk("post_rst_grant", {6'b0, last_act[0], last_act[2], last_act[7:6]}, {6'b0, 1'b1, 1'b0, 2'd3});
      idle(1'b1, 1'b1);
      chk("post_rst_second", {6'b0, last_act[0], last_act[2], last_act[5:4]}, {6'b0, 1'b1, 1'b1, 2'd1});

      // Random traffic with random backpressure.
      reset_pulse("reset_rand");
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom), 2'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom), 1'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
